// File: rtl/sign_extend_unit.sv
// Registered widening stage: 18-bit immediate and 22-bit displacement to 32 bits, 1-cycle latency.
// Build with ZEXT_EN defined to honour the zext port; otherwise both paths always sign-extend.
module sign_extend_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [17:0] imm_in,
  input  logic [21:0] md_in,
  input  logic        zext,
  output logic        out_valid,
  output logic [31:0] imm_out,
  output logic [31:0] md_out,
  output logic        imm_neg,
  output logic        md_neg
);

  logic        use_zext;
  logic [31:0] imm_ext, md_ext;
  logic        valid_q;
  logic [31:0] imm_q, md_q;
  logic        imm_neg_q, md_neg_q;

`ifdef ZEXT_EN
  assign use_zext = zext;
`else
  // Port kept so both builds share one port list; its value is ignored.
  logic unused_zext;
  assign unused_zext = zext;
  assign use_zext    = 1'b0;
`endif

  always_comb begin
    imm_ext = {{14{imm_in[17] & ~use_zext}}, imm_in};
    md_ext  = {{10{md_in[21] & ~use_zext}}, md_in};
  end

  // Data registers only load on in_valid, so idle-cycle garbage on the fields never reaches them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      imm_q     <= 32'h0;
      md_q      <= 32'h0;
      imm_neg_q <= 1'b0;
      md_neg_q  <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        imm_q     <= imm_ext;
        md_q      <= md_ext;
        imm_neg_q <= imm_ext[31];
        md_neg_q  <= md_ext[31];
      end
    end
  end

  assign out_valid = valid_q;
  assign imm_out   = imm_q;
  assign md_out    = md_q;
  assign imm_neg   = imm_neg_q;
  assign md_neg    = md_neg_q;

endmodule

// File: tb/tb_sign_extend_unit.sv
// Self-checking bench for sign_extend_unit: directed vector table plus sweeps, hold and reset cases.
module tb_sign_extend_unit;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [17:0] imm_in;
  logic [21:0] md_in;
  logic        zext;
  logic        out_valid;
  logic [31:0] imm_out;
  logic [31:0] md_out;
  logic        imm_neg;
  logic        md_neg;

  int n_checks = 0;
  int n_fail   = 0;

  sign_extend_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .imm_in    (imm_in),
    .md_in     (md_in),
    .zext      (zext),
    .out_valid (out_valid),
    .imm_out   (imm_out),
    .md_out    (md_out),
    .imm_neg   (imm_neg),
    .md_neg    (md_neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] imm;
    logic [21:0] md;
    logic        zx;
    logic [31:0] exp_imm;
    logic [31:0] exp_md;
    logic        exp_imm_neg;
    logic        exp_md_neg;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [17:0] imm, input logic [21:0] md,
                       input logic zx);
    @(negedge clk);
    in_valid = v;
    imm_in   = imm;
    md_in    = md;
    zext     = zx;
  endtask

  task automatic sample;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    imm_in   = '0;
    md_in    = '0;
    zext     = 1'b0;

    //            imm        md          zx    exp_imm       exp_md        in   mn
    vecs[0] = '{18'h20000, 22'h000000, 1'b0, 32'hFFFE0000, 32'h00000000, 1'b1, 1'b0};
    vecs[1] = '{18'h3FFFF, 22'h1FFFFF, 1'b0, 32'hFFFFFFFF, 32'h001FFFFF, 1'b1, 1'b0};
    vecs[2] = '{18'h1FFFF, 22'h200000, 1'b0, 32'h0001FFFF, 32'hFFE00000, 1'b0, 1'b1};
    vecs[3] = '{18'h2ABCD, 22'h3FFFFF, 1'b0, 32'hFFFEABCD, 32'hFFFFFFFF, 1'b1, 1'b1};
    vecs[4] = '{18'h00001, 22'h155555, 1'b0, 32'h00000001, 32'h00155555, 1'b0, 1'b0};
`ifdef ZEXT_EN
    vecs[5] = '{18'h3FFFF, 22'h3FFFFF, 1'b1, 32'h0003FFFF, 32'h003FFFFF, 1'b0, 1'b0};
    vecs[6] = '{18'h20000, 22'h200000, 1'b1, 32'h00020000, 32'h00200000, 1'b0, 1'b0};
`else
    vecs[5] = '{18'h3FFFF, 22'h3FFFFF, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1};
    vecs[6] = '{18'h20000, 22'h200000, 1'b1, 32'hFFFE0000, 32'hFFE00000, 1'b1, 1'b1};
`endif
    vecs[7] = '{18'h1FFFF, 22'h1FFFFF, 1'b1, 32'h0001FFFF, 32'h001FFFFF, 1'b0, 1'b0};

    // Reset state
    #12;
    check("reset_out_valid", {31'b0, out_valid}, 32'h0);
    check("reset_imm_out", imm_out, 32'h0);
    check("reset_md_out", md_out, 32'h0);
    check("reset_negs", {30'b0, imm_neg, md_neg}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Immediate sweep, back to back
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 18'(i), 22'h0, 1'b0);
      sample();
      check("imm_sweep_imm", imm_out, 32'(i));
      check("imm_sweep_md", md_out, 32'h0);
      check("imm_sweep_valid", {31'b0, out_valid}, 32'h1);
    end

    // Displacement sweep, back to back
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 18'h0, 22'(i), 1'b0);
      sample();
      check("md_sweep_md", md_out, 32'(i));
      check("md_sweep_valid", {31'b0, out_valid}, 32'h1);
    end

    // Directed boundary vectors
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].imm, vecs[i].md, vecs[i].zx);
      sample();
      check($sformatf("vec%0d_imm", i), imm_out, vecs[i].exp_imm);
      check($sformatf("vec%0d_md", i), md_out, vecs[i].exp_md);
      check($sformatf("vec%0d_imm_neg", i), {31'b0, imm_neg}, {31'b0, vecs[i].exp_imm_neg});
      check($sformatf("vec%0d_md_neg", i), {31'b0, md_neg}, {31'b0, vecs[i].exp_md_neg});
      check($sformatf("vec%0d_valid", i), {31'b0, out_valid}, 32'h1);
    end

    // Hold: capture then idle with changing inputs
    drive(1'b1, 18'h2ABCD, 22'h000123, 1'b0);
    sample();
    check("hold_capture", imm_out, 32'hFFFEABCD);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 18'($urandom), 22'($urandom), 1'($urandom));
      sample();
      check("hold_imm", imm_out, 32'hFFFEABCD);
      check("hold_md", md_out, 32'h00000123);
      check("hold_imm_neg", {31'b0, imm_neg}, 32'h1);
      check("hold_valid", {31'b0, out_valid}, 32'h0);
    end

    // Asynchronous reset mid-stream, between edges
    drive(1'b1, 18'h3FFFF, 22'h3FFFFF, 1'b0);
    sample();
    check("pre_reset_imm", imm_out, 32'hFFFFFFFF);
    drive(1'b1, 18'h20000, 22'h200000, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_imm", imm_out, 32'h0);
    check("async_reset_md", md_out, 32'h0);
    check("async_reset_flags", {29'b0, out_valid, imm_neg, md_neg}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 18'h00ABC, 22'h200001, 1'b0);
    sample();
    check("post_reset_imm", imm_out, 32'h00000ABC);
    check("post_reset_md", md_out, 32'hFFE00001);
    check("post_reset_flags", {29'b0, out_valid, imm_neg, md_neg}, 32'h5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
